// File: rtl/multi_write_ram.sv
// Multi-write, single-read RAM: one private bank per write port, with a Live Value Table selecting the newest bank.
// Optional write-write collision flag, enabled by defining MULTI_WRITE_RAM_COLLISION_EN.
module multi_write_ram #(
    parameter int    DATA_DEPTH = 128,
    parameter int    DATA_WIDTH = 64,
    parameter int    WPORTS_NUM = 4,
    parameter string WRITE_MODE = "write_first",
    localparam int   ADDR_WIDTH = $clog2(DATA_DEPTH),
    localparam int   LVT_WIDTH  = $clog2(WPORTS_NUM)
) (
    input  logic                             clk,
    input  logic                             a_rst,
    input  logic [WPORTS_NUM-1:0]            en_w_i,
    input  logic [WPORTS_NUM*ADDR_WIDTH-1:0] waddr_i,
    input  logic [WPORTS_NUM*DATA_WIDTH-1:0] data_w_i,
    input  logic                             en_r_i,
    input  logic [ADDR_WIDTH-1:0]            raddr_i,
    output logic [DATA_WIDTH-1:0]            data_o,
    output logic                             valid_o,
    output logic                             collision_o
);

    localparam bit                  WRITE_FIRST = (WRITE_MODE == "write_first");
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM   = (ADDR_WIDTH + 1)'(DATA_DEPTH);

    logic [ADDR_WIDTH-1:0] waddr_s   [WPORTS_NUM];
    logic [DATA_WIDTH-1:0] wdata_s   [WPORTS_NUM];
    logic [WPORTS_NUM-1:0] wr_s;
    logic [DATA_WIDTH-1:0] bank_rd_s [WPORTS_NUM];
    logic [LVT_WIDTH-1:0]  lvt_r     [DATA_DEPTH];
    logic [LVT_WIDTH-1:0]  rd_sel_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic                  fwd_hit_s;
    logic [DATA_WIDTH-1:0] fwd_data_s;
    logic [DATA_WIDTH-1:0] next_data_s;
    logic                  collision_s;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  valid_r;
    logic                  collision_r;

    // Unpack write ports; out-of-range addresses never write.
    always_comb begin
        for (int p = 0; p < WPORTS_NUM; p++) begin
            waddr_s[p] = waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_s[p] = data_w_i[p*DATA_WIDTH +: DATA_WIDTH];
            wr_s[p]    = en_w_i[p] && ({1'b0, waddr_s[p]} < DEPTH_LIM);
        end
    end

    genvar g;
    generate
        for (g = 0; g < WPORTS_NUM; g++) begin : g_bank
            logic [DATA_WIDTH-1:0] mem_r [DATA_DEPTH];

            // Private bank storage, written only by its own port; contents survive reset.
            always_ff @(posedge clk) begin
                if (wr_s[g]) begin
                    mem_r[waddr_s[g]] <= wdata_s[g];
                end
            end

            assign bank_rd_s[g] = mem_r[raddr_i];
        end
    endgenerate

    // Live Value Table; later loop iterations override earlier ones, so the highest port wins a tie.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            for (int i = 0; i < DATA_DEPTH; i++) begin
                lvt_r[i] <= '0;
            end
        end else begin
            for (int p = 0; p < WPORTS_NUM; p++) begin
                if (wr_s[p]) begin
                    lvt_r[waddr_s[p]] <= LVT_WIDTH'(p);
                end
            end
        end
    end

    // Bank selection through the LVT, plus same-cycle forwarding from the highest hitting port.
    always_comb begin
        rd_sel_s   = lvt_r[raddr_i];
        rd_data_s  = bank_rd_s[rd_sel_s];
        fwd_hit_s  = 1'b0;
        fwd_data_s = '0;
        for (int p = 0; p < WPORTS_NUM; p++) begin
            fwd_data_s = (wr_s[p] && (waddr_s[p] == raddr_i)) ? wdata_s[p] : fwd_data_s;
            fwd_hit_s  = fwd_hit_s | (wr_s[p] && (waddr_s[p] == raddr_i));
        end
        if (WRITE_FIRST && fwd_hit_s) begin
            next_data_s = fwd_data_s;
        end else begin
            next_data_s = rd_data_s;
        end
    end

`ifdef MULTI_WRITE_RAM_COLLISION_EN
    // Pairwise address compare across all enabled write ports.
    always_comb begin
        collision_s = 1'b0;
        for (int i = 0; i < WPORTS_NUM; i++) begin
            for (int j = i + 1; j < WPORTS_NUM; j++) begin
                collision_s = collision_s |
                              (en_w_i[i] && en_w_i[j] && (waddr_s[i] == waddr_s[j]));
            end
        end
    end
`else
    assign collision_s = 1'b0;
`endif

    // Registered read data, valid and collision outputs.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            data_r      <= '0;
            valid_r     <= 1'b0;
            collision_r <= 1'b0;
        end else begin
            valid_r     <= en_r_i;
            collision_r <= collision_s;
            if (en_r_i) begin
                data_r <= next_data_s;
            end
        end
    end

    assign data_o      = data_r;
    assign valid_o     = valid_r;
    assign collision_o = collision_r;

endmodule

// File: tb/tb_multi_write_ram.sv
// Randomized self-checking bench for multi_write_ram against an address-level reference model.
module tb_multi_write_ram;

    localparam string MODE = "write_first";
    localparam bit    WF   = (MODE == "write_first");
`ifdef MULTI_WRITE_RAM_COLLISION_EN
    localparam bit    COLL_EN = 1'b1;
`else
    localparam bit    COLL_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             a_rst;
    logic [3:0]       en_w;
    logic [3:0][6:0]  wa;
    logic [3:0][63:0] wd;
    logic             en_r;
    logic [6:0]       raddr;
    logic [63:0]      data_o;
    logic             valid_o;
    logic             collision_o;

    int checks = 0;
    int errors = 0;

    // Model: newest value per address, plus what bank 0 holds (it survives reset).
    logic [63:0] ref_mem     [128];
    bit          ref_known   [128];
    logic [63:0] bank0_mem   [128];
    bit          bank0_known [128];
    logic [63:0] exp_data;
    bit          exp_known;

    multi_write_ram #(.WRITE_MODE(MODE)) dut (
        .clk        (clk),
        .a_rst      (a_rst),
        .en_w_i     (en_w),
        .waddr_i    (wa),
        .data_w_i   (wd),
        .en_r_i     (en_r),
        .raddr_i    (raddr),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .collision_o(collision_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        en_w = 4'b0;
        en_r = 1'b0;
    endtask

    // One clock of traffic: predict, advance the model, then compare just after the edge.
    task automatic step();
        logic e_valid;
        logic e_coll;
        bit   hit;
        e_valid = en_r;
        e_coll  = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (en_w[i] && en_w[j] && wa[i] == wa[j]) e_coll = 1'b1;
        e_coll = e_coll & COLL_EN;
        if (en_r) begin
            hit = 1'b0;
            for (int p = 0; p < 4; p++) begin
                if (WF && en_w[p] && wa[p] == raddr) begin
                    hit      = 1'b1;
                    exp_data = wd[p];
                end
            end
            if (hit) begin
                exp_known = 1'b1;
            end else begin
                exp_known = ref_known[raddr];
                exp_data  = ref_mem[raddr];
            end
        end
        for (int p = 0; p < 4; p++) begin
            if (en_w[p]) begin
                ref_mem[wa[p]]   = wd[p];
                ref_known[wa[p]] = 1'b1;
                if (p == 0) begin
                    bank0_mem[wa[p]]   = wd[p];
                    bank0_known[wa[p]] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        check("valid", {63'd0, valid_o}, {63'd0, e_valid});
        check("collision", {63'd0, collision_o}, {63'd0, e_coll});
        if (exp_known) check("data", data_o, exp_data);
    endtask

    task automatic wr(input int p, input logic [6:0] a, input logic [63:0] d);
        en_w[p] = 1'b1;
        wa[p]   = a;
        wd[p]   = d;
    endtask

    task automatic rd(input logic [6:0] a);
        en_r  = 1'b1;
        raddr = a;
    endtask

    initial begin
        a_rst = 1'b1;
        wa    = '0;
        wd    = '0;
        raddr = 7'd0;
        idle();
        for (int a = 0; a < 128; a++) begin
            ref_known[a]   = 1'b0;
            bank0_known[a] = 1'b0;
            ref_mem[a]     = 64'd0;
            bank0_mem[a]   = 64'd0;
        end
        exp_data  = 64'd0;
        exp_known = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", data_o, 64'd0);
        check("rst_valid", {63'd0, valid_o}, 64'd0);
        check("rst_coll", {63'd0, collision_o}, 64'd0);
        a_rst = 1'b0;

        // Bank 0 gets a value at addr 5 so the post-reset read is defined.
        idle(); wr(0, 7'd5, 64'h50); step();
        idle(); wr(2, 7'd5, 64'hA5); step();
        idle(); rd(7'd5); step();
        check("tp_single", data_o, 64'hA5);
        check("tp_single_v", {63'd0, valid_o}, 64'd1);

        idle(); wr(1, 7'd3, 64'h22); step();
        idle(); wr(0, 7'd3, 64'h11); rd(7'd3); step();
        check("tp_same", data_o, WF ? 64'h11 : 64'h22);
        idle(); rd(7'd3); step();
        check("tp_same_after", data_o, 64'h11);

        idle(); wr(1, 7'd7, 64'h100); wr(3, 7'd7, 64'h300); step();
        check("tp_coll", {63'd0, collision_o}, COLL_EN ? 64'd1 : 64'd0);
        idle(); rd(7'd7); step();
        check("tp_coll_data", data_o, 64'h300);

        idle(); wr(3, 7'd9, 64'hBB); step();
        idle(); wr(0, 7'd9, 64'hCC); step();
        idle(); rd(7'd9); step();
        check("tp_cross", data_o, 64'hCC);

        idle(); wr(1, 7'd10, 64'h55); step();
        idle(); rd(7'd10); step();
        for (int k = 0; k < 3; k++) begin
            idle(); step();
            check("tp_hold", data_o, 64'h55);
            check("tp_hold_v", {63'd0, valid_o}, 64'd0);
        end

        // Reset pulse between edges while writes are being presented.
        idle(); rd(7'd10); step();
        idle(); wr(1, 7'd7, 64'h1); wr(3, 7'd7, 64'h3); wr(2, 7'd5, 64'hEE);
        #2 a_rst = 1'b1;
        #1;
        check("tp_rst_data", data_o, 64'd0);
        check("tp_rst_valid", {63'd0, valid_o}, 64'd0);
        check("tp_rst_coll", {63'd0, collision_o}, 64'd0);
        for (int a = 0; a < 128; a++) begin
            ref_mem[a]   = bank0_mem[a];
            ref_known[a] = bank0_known[a];
        end
        exp_data  = 64'd0;
        exp_known = 1'b1;
        #2 a_rst = 1'b0;
        idle();
        @(posedge clk);
        #1;
        idle(); rd(7'd5); step();
        check("tp_rst_read", data_o, 64'h50);

        for (int n = 0; n < 1500; n++) begin
            en_w = 4'($urandom_range(0, 15));
            for (int p = 0; p < 4; p++) begin
                wa[p] = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127))
                                                    : 7'($urandom_range(0, 15));
                wd[p] = {$urandom, $urandom};
            end
            en_r  = ($urandom_range(0, 3) != 0);
            raddr = 7'($urandom_range(0, 15));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_write_ram.md
# multi_write_ram

Multi-write, single-read RAM with WPORTS_NUM independent write ports and one synchronous read port on a single clock. Each write port owns a private bank, and a registered Live Value Table (LVT) records which bank holds the latest value of each address. The read port uses the LVT to select the correct bank. It is the write-side counterpart of the multi-read RAM and is used where several producers must update shared tables, such as rename maps and scoreboards, that have a single consumer.

## Interface
- DATA_DEPTH, 128, number of words; ADDR_WIDTH = $clog2(DATA_DEPTH).
- DATA_WIDTH, 64, word width in bits.
- WPORTS_NUM, 4, number of write ports, 2..8; LVT_WIDTH = $clog2(WPORTS_NUM).
- WRITE_MODE, "write_first", same-cycle read/write behaviour: "write_first" or "read_first".

Ports:
- clk  in  1  single clock for all ports.
- a_rst  in  1  asynchronous reset, active-high.
- en_w_i  in  WPORTS_NUM  per-port write enable.
- waddr_i  in  WPORTS_NUM x ADDR_WIDTH  per-port write address.
- data_w_i  in  WPORTS_NUM x DATA_WIDTH  per-port write data.
- en_r_i  in  1  read enable.
- raddr_i  in  ADDR_WIDTH  read address.
- data_o  out  DATA_WIDTH  read data, registered.
- valid_o  out  1  data_o was updated by a read issued the previous cycle.
- collision_o  out  1  write-write collision flag (see Configuration).

## Operation
- Bank p is written only by write port p. All banks are read in parallel at raddr_i.
- LVT: DATA_DEPTH x LVT_WIDTH register array.
  - When en_w_i[p] is high, lvt[waddr_i[p]] <= p.
- Same-address writes in one cycle:
  - Every enabled port writes its own bank.
  - The LVT takes the highest enabled port index, so the highest port wins.
- Read, WRITE_MODE="read_first":
  - data_o <= bank[lvt[raddr_i]][raddr_i], using LVT and bank contents before this cycle's writes.
- Read, WRITE_MODE="write_first":
  - If any enabled write port hits raddr_i in the same cycle, data_o <= data_w_i of the highest such port.
  - Otherwise, behaviour is the same as read_first.
- When en_r_i is low, data_o holds its value and valid_o <= 0.
- Reset:
  - Clears the whole LVT to 0 (bank 0), and clears data_o, valid_o and collision_o to 0.
  - Bank contents are not reset, so any address not rewritten after reset returns bank 0 content. This is undefined (X in simulation) until that address is written.
  - A reset in the middle of operation logically discards all prior writes.
- Addresses >= DATA_DEPTH, when DATA_DEPTH is not a power of two, are ignored for writes; reads of such addresses return undefined data.

## Timing
- Read latency is 1 cycle: read issued at cycle t gives data_o and valid_o at t+1.
- Write at cycle t is visible to a read issued at t+1 in both modes, and at t in write_first.
- Back-to-back reads and writes every cycle are supported on all ports; there is no stall and no handshake.
- LVT update and bank write complete in the same clock edge.
- Reset values: data_o = 0, valid_o = 0, collision_o = 0. Reset assertion takes effect immediately (asynchronous); release is synchronous to clk.

## Configuration
- MULTI_WRITE_RAM_COLLISION_EN defined:
  - collision_o is a registered pulse at t+1 when two or more write ports are enabled with equal waddr_i at cycle t.
  - Collision detection uses a pairwise address comparison over all port pairs.
- Macro not defined:
  - collision_o is tied to 0 and no comparator logic is built.
  - Same-address priority (highest port wins) is unchanged in both builds.

## Test plan
- Single write, then read: port 2 writes 0xA5 to addr 5 at t, read addr 5 at t+1 -> data_o=0xA5, valid_o=1 at t+2.
- Same-cycle read and write: port 0 writes 0x11 to addr 3 at t with a read of addr 3 at t; prior value 0x22 -> write_first gives data_o=0x11 at t+1, read_first gives 0x22.
- Write-write collision: ports 1 and 3 write 0x100 and 0x300 to addr 7 at t -> a later read of addr 7 returns 0x300, and collision_o=1 at t+1 when the macro is defined (0 when it is not).
- Cross-port overwrite: port 3 writes 0xBB to addr 9, then port 0 writes 0xCC to addr 9 -> read returns 0xCC, i.e. the LVT tracks the latest writer, not the highest index.
- Read hold: en_r_i=0 for 3 cycles after a read of 0x55 -> data_o stays 0x55 and valid_o=0.
- Reset mid-operation: a_rst pulses while writes are active -> data_o=0, valid_o=0 and collision_o=0 immediately, the LVT is all 0, and a read of addr 5 (last written by port 2) then returns bank 0 content.
